// File: rtl/secded_stream_dec.sv
// Multi-mode extended-Hamming (SECDED) stream decoder: 2-stage stall-all pipeline, mode travels with each word.
// Optional saturating error counters (cnt_clr/corr_cnt/det_cnt) are built when SECDED_ERR_CNT_EN is defined.
module secded_stream_dec #(
    parameter  int MAX_CODEWORD_WIDTH = 32,
    localparam int PAR_W              = $clog2(MAX_CODEWORD_WIDTH) + 1,
    localparam int MAX_INFO_WIDTH     = MAX_CODEWORD_WIDTH - PAR_W,
    localparam int NUM_MODES          = $clog2(MAX_CODEWORD_WIDTH) - 2,
    localparam int POS_W              = PAR_W - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    status,
    output logic [POS_W-1:0]              err_pos
`ifdef SECDED_ERR_CNT_EN
    ,
    input  logic                          cnt_clr,
    output logic [15:0]                   corr_cnt,
    output logic [15:0]                   det_cnt
`endif
);
    localparam int CW = MAX_CODEWORD_WIDTH;

    function automatic logic [CW-1:0] cw_mask_f(input logic [1:0] mode);
        logic [CW-1:0] m;
        int n;
        n = 32'sd8 << mode;
        m = '0;
        for (int p = 0; p < CW; p++) begin
            m[p] = (p < n);
        end
        return m;
    endfunction

    function automatic logic [POS_W-1:0] syndrome_f(input logic [CW-1:0] cw);
        logic [POS_W-1:0] s;
        s = '0;
        for (int p = 1; p < CW; p++) begin
            for (int i = 0; i < POS_W; i++) begin
                s[i] = s[i] ^ (cw[p] & p[i]);
            end
        end
        return s;
    endfunction

    // Codeword position of info bit idx: the idx-th non-power-of-two position from 3 upward.
    function automatic int info_pos_f(input int idx);
        int cnt;
        int pos;
        cnt = 32'sd0;
        pos = 32'sd0;
        for (int p = 3; p < CW; p++) begin
            if (((p & (p - 32'sd1)) != 32'sd0) && (cnt == idx)) pos = p;
            if ((p & (p - 32'sd1)) != 32'sd0) cnt = cnt + 32'sd1;
        end
        return pos;
    endfunction

    logic                      w_adv;
    logic [CW-1:0]             w_cw;
    logic [CW-1:0]             w_fixed;
    logic [MAX_INFO_WIDTH-1:0] w_info;
    logic [MAX_INFO_WIDTH-1:0] w_data;
    logic [1:0]                w_status;
    logic [POS_W-1:0]          w_pos;

    logic                      r1_valid;
    logic [CW-1:0]             r1_cw;
    logic                      r1_illegal;
    logic [POS_W-1:0]          r1_syn;
    logic                      r1_ovp;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_cw     = data_in & cw_mask_f(work_mod);

    // Stage 1: masked codeword, mode legality, syndrome and overall parity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_valid   <= 1'b0;
            r1_cw      <= '0;
            r1_illegal <= 1'b0;
            r1_syn     <= '0;
            r1_ovp     <= 1'b0;
        end else if (w_adv) begin
            r1_valid   <= in_valid;
            r1_cw      <= w_cw;
            r1_illegal <= (int'(work_mod) >= NUM_MODES);
            r1_syn     <= syndrome_f(w_cw);
            r1_ovp     <= ^w_cw;
        end
    end

    // Correction, info extraction and classification; a double error keeps the raw extraction.
    always_comb begin
        w_fixed = r1_cw;
        if (r1_ovp) begin
            w_fixed[r1_syn] = ~r1_cw[r1_syn];
        end else begin
            w_fixed = r1_cw;
        end
        w_info = '0;
        for (int j = 0; j < MAX_INFO_WIDTH; j++) begin
            w_info[j] = w_fixed[info_pos_f(j)];
        end
        w_data   = w_info;
        w_status = 2'b00;
        w_pos    = '0;
        if (r1_illegal) begin
            w_status = 2'b11;
            w_data   = '0;
        end else if (r1_ovp) begin
            w_status = 2'b01;
            w_pos    = r1_syn;
        end else if (r1_syn != '0) begin
            w_status = 2'b10;
        end else begin
            w_status = 2'b00;
        end
    end

    // Stage 2: registered result, held while the sink stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            status    <= 2'b00;
            err_pos   <= '0;
        end else if (w_adv) begin
            out_valid <= r1_valid;
            if (r1_valid) begin
                data_out <= w_data;
                status   <= w_status;
                err_pos  <= w_pos;
            end
        end
    end

`ifdef SECDED_ERR_CNT_EN
    // Saturating error counters advance on output transfers; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_cnt <= 16'h0000;
            det_cnt  <= 16'h0000;
        end else if (cnt_clr) begin
            corr_cnt <= 16'h0000;
            det_cnt  <= 16'h0000;
        end else if (out_valid && out_ready) begin
            if ((status == 2'b01) && (corr_cnt != 16'hFFFF)) corr_cnt <= corr_cnt + 16'd1;
            if ((status == 2'b10) && (det_cnt != 16'hFFFF)) det_cnt <= det_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_secded_stream_dec.sv
// Self-checking bench for secded_stream_dec: directed steps plus an expected-result queue checked at the output.
// Counter checks are included when SECDED_ERR_CNT_EN is defined.
module tb_secded_stream_dec;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  work_mod;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] data_out;
    logic [1:0]  status;
    logic [4:0]  err_pos;
`ifdef SECDED_ERR_CNT_EN
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] det_cnt;
`endif

    typedef struct packed {
        logic [25:0] d;
        logic [1:0]  s;
        logic [4:0]  p;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    secded_stream_dec #(.MAX_CODEWORD_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .work_mod  (work_mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .status    (status),
        .err_pos   (err_pos)
`ifdef SECDED_ERR_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .corr_cnt  (corr_cnt),
        .det_cnt   (det_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference encoder: info into non-power-of-two positions, Hamming parity at 2^i, overall parity at 0.
    function automatic logic [31:0] encode(input logic [25:0] info, input int m);
        logic [31:0] cw;
        logic        par;
        int          n;
        int          j;
        n  = 8 << m;
        cw = 32'd0;
        j  = 0;
        for (int p = 3; p < n; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = info[j];
                j++;
            end
        end
        for (int i = 0; (1 << i) < n; i++) begin
            par = 1'b0;
            for (int p = 1; p < n; p++) begin
                if (((p >> i) & 1) == 1) par = par ^ cw[p];
            end
            cw[1 << i] = par;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    task automatic drive_word(input logic [31:0] cw, input logic [1:0] mode,
                              input logic [25:0] ed, input logic [1:0] es, input logic [4:0] ep);
        in_valid = 1'b1;
        data_in  = cw;
        work_mod = mode;
        sb_q.push_back({ed, es, ep});
    endtask

    task automatic wait_accept();
        logic got;
        got = 1'b0;
        for (int g = 0; g < 64 && !got; g++) begin
            @(negedge clk);
            got = in_ready;
        end
        check("in_accept", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] cw, input logic [1:0] mode,
                        input logic [25:0] ed, input logic [1:0] es, input logic [4:0] ep);
        drive_word(cw, mode, ed, es, ep);
        wait_accept();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int g = 0; g < 200 && sb_q.size() != 0; g++) @(posedge clk);
        #1;
        check("drain_empty", sb_q.size(), 32'd0);
    endtask

    // Output scoreboard: every valid output is compared with the oldest expectation, popped on transfer.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            check("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                check("data_out", 32'(data_out), 32'(sb_q[0].d));
                check("status", 32'(status), 32'(sb_q[0].s));
                check("err_pos", 32'(err_pos), 32'(sb_q[0].p));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [25:0] info;
        logic [31:0] cw;
        logic [31:0] garb;
        int          n;
        int          k;

        rst       = 1'b0;
        in_valid  = 1'b0;
        data_in   = 32'd0;
        work_mod  = 2'd0;
        out_ready = 1'b1;
`ifdef SECDED_ERR_CNT_EN
        cnt_clr   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_err_pos", 32'(err_pos), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accepted at edge E1, result visible after E2.
        send(32'h000000AA, 2'd0, 26'hB, 2'b00, 5'd0);
        in_valid = 1'b0;
        check("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        send(32'h0000008A, 2'd0, 26'hB, 2'b01, 5'd5);
        send(32'h000000AB, 2'd0, 26'hB, 2'b01, 5'd0);
        send(32'h000000AC, 2'd0, 26'hB, 2'b10, 5'd0);
        send(32'hFFFFFFAA, 2'd0, 26'hB, 2'b00, 5'd0);
        send(32'hDEADBEEF, 2'd3, 26'h0, 2'b11, 5'd0);
        drain();

        for (int m = 0; m < 3; m++) begin
            n    = 8 << m;
            k    = n - m - 4;
            info = 26'($urandom) & 26'((32'd1 << k) - 32'd1);
            cw   = encode(info, m);
            garb = (m < 2) ? ($urandom << n) : 32'd0;
            send(cw | garb, 2'(m), info, 2'b00, 5'd0);
            for (int p = 0; p < n; p++) begin
                garb = (m < 2) ? ($urandom << n) : 32'd0;
                send((cw ^ (32'd1 << p)) | garb, 2'(m), info, 2'b01, 5'(p));
            end
        end
        drain();

        // Backpressure: sink stalls once the first result appears.
        out_ready = 1'b0;
        send(32'h000000AA, 2'd0, 26'hB, 2'b00, 5'd0);
        send(32'h0000008A, 2'd0, 26'hB, 2'b01, 5'd5);
        drive_word(32'h000000AB, 2'd0, 26'hB, 2'b01, 5'd0);
        for (int c = 0; c < 3; c++) begin
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept();
        send(32'h000000AC, 2'd0, 26'hB, 2'b10, 5'd0);
        drain();

        // Reset with two words in flight.
        send(32'h000000AA, 2'd0, 26'hB, 2'b00, 5'd0);
        send(32'h0000008A, 2'd0, 26'hB, 2'b01, 5'd5);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_status", 32'(status), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        send(32'h000000AB, 2'd0, 26'hB, 2'b01, 5'd0);
        drain();

`ifdef SECDED_ERR_CNT_EN
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_clr_corr", 32'(corr_cnt), 32'd0);
        send(32'h0000008A, 2'd0, 26'hB, 2'b01, 5'd5);
        send(32'h000000AC, 2'd0, 26'hB, 2'b10, 5'd0);
        send(32'h000000AB, 2'd0, 26'hB, 2'b01, 5'd0);
        send(32'h000000A9, 2'd0, 26'hB, 2'b10, 5'd0);
        send(32'h000000EA, 2'd0, 26'hB, 2'b01, 5'd6);
        drain();
        @(posedge clk);
        #1;
        check("corr_cnt", 32'(corr_cnt), 32'd3);
        check("det_cnt", 32'(det_cnt), 32'd2);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_corr_cnt", 32'(corr_cnt), 32'd0);
        check("clr_det_cnt", 32'(det_cnt), 32'd0);
`endif

        check("final_queue", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
